// File: rtl/count_frame_serializer_pkg.sv
// Shared types and constants for the count frame serializer.
package count_frame_serializer_pkg;

  // Frame transmit states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } frame_state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam int unsigned NWORDS = 11;
  localparam int unsigned WORD_W = 4;

  // Word positions in the detector's flattened count bus
  localparam int unsigned WORD_CLK = 0;
  localparam int unsigned WORD_A   = 1;
  localparam int unsigned WORD_B   = 2;
  localparam int unsigned WORD_C   = 3;
  localparam int unsigned WORD_D   = 4;
  localparam int unsigned WORD_AB  = 5;
  localparam int unsigned WORD_AC  = 6;
  localparam int unsigned WORD_AD  = 7;
  localparam int unsigned WORD_BC  = 8;
  localparam int unsigned WORD_BD  = 9;
  localparam int unsigned WORD_CD  = 10;

  // Bytes needed to carry one count word
  function automatic int unsigned nbytes_for(input int unsigned nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/count_snapshot_mux.sv
// Snapshot registers for the 11 count words plus byte selection, MSB byte first.
module count_snapshot_mux
  import count_frame_serializer_pkg::*;
#(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned NBYTES = 1,
  parameter int unsigned BSEL_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [NWORDS*NBITS-1:0] counts_in,
  input  logic [WORD_W-1:0]       word_sel,
  input  logic [BSEL_W-1:0]       byte_sel,
  output logic [7:0]              byte_c
);

  localparam int unsigned EXT_W = 8 * NBYTES;

  logic [NBITS-1:0] snap [NWORDS];
  logic [NBITS-1:0] sel_word;
  logic [EXT_W-1:0] ext;

  // Capture all count words together when a frame is started
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) snap[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NWORDS; i++) snap[i] <= counts_in[i*NBITS +: NBITS];
    end
  end

  // Pick the word, zero-extend it, then take the requested byte (index 0 = MSB)
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (word_sel == WORD_W'(i)) sel_word = snap[i];
    end
    ext    = EXT_W'(sel_word);
    byte_c = 8'(ext >> (8 * (int'(NBYTES) - 1 - int'(byte_sel))));
  end

endmodule

// File: rtl/count_frame_serializer.sv
// Streams a snapshot of the detector counts as a checksummed byte frame.
module count_frame_serializer
  import count_frame_serializer_pkg::*;
#(
  parameter int unsigned NBITS    = 4,
  parameter logic [7:0]  HEADER   = HEADER_DEFAULT,
  parameter int unsigned OVF_BITS = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Enable,
  input  logic                    Window_Done,
  input  logic [NWORDS*NBITS-1:0] Counts_In,
  output logic [7:0]              Tx_Data,
  output logic                    Tx_Valid,
  input  logic                    Tx_Ready,
  output logic                    Busy,
  output logic [7:0]              Frame_Seq,
  output logic [OVF_BITS-1:0]     Overrun_Cnt
);

  localparam int unsigned NBYTES = nbytes_for(NBITS);
  localparam int unsigned BSEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  frame_state_e         state, state_next;
  logic [WORD_W-1:0]    word_idx, word_next;
  logic [BSEL_W-1:0]    bsel, bsel_next;
  logic [7:0]           checksum, chk_next;
  logic [7:0]           data_next, seq_next, mux_byte;
  logic [OVF_BITS-1:0]  ovf_next;
  logic                 valid_next, busy_next;
  logic                 hs, start, load, last_byte, last_word;

  assign hs        = Tx_Valid & Tx_Ready;
  assign start     = Window_Done & Enable;
  // A new window is accepted when idle or exactly as the checksum byte leaves
  assign load      = start & ((state == IDLE) | ((state == CHK) & hs));
  assign last_byte = (bsel == BSEL_W'(NBYTES - 1));
  assign last_word = (word_idx == WORD_W'(WORD_CD));

  count_snapshot_mux #(
    .NBITS  (NBITS),
    .NBYTES (NBYTES),
    .BSEL_W (BSEL_W)
  ) u_snap (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load      (load),
    .counts_in (Counts_In),
    .word_sel  (word_next),
    .byte_sel  (bsel_next),
    .byte_c    (mux_byte)
  );

  // State, indices, checksum and registered outputs
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= IDLE;
      word_idx    <= '0;
      bsel        <= '0;
      checksum    <= '0;
      Tx_Valid    <= 1'b0;
      Tx_Data     <= '0;
      Busy        <= 1'b0;
      Frame_Seq   <= '0;
      Overrun_Cnt <= '0;
    end else begin
      state       <= state_next;
      word_idx    <= word_next;
      bsel        <= bsel_next;
      checksum    <= chk_next;
      Tx_Valid    <= valid_next;
      Tx_Data     <= data_next;
      Busy        <= busy_next;
      Frame_Seq   <= seq_next;
      Overrun_Cnt <= ovf_next;
    end
  end

  // Next state and byte position; advances only on a handshake
  always_comb begin
    state_next = state;
    word_next  = word_idx;
    bsel_next  = bsel;
    case (state)
      IDLE: if (start) state_next = HDR;
      HDR:  if (hs) state_next = SEQ;
      SEQ: begin
        if (hs) begin
          state_next = DATA;
          word_next  = '0;
          bsel_next  = '0;
        end
      end
      DATA: begin
        if (hs) begin
          if (last_byte) begin
            bsel_next = '0;
            if (last_word) state_next = CHK;
            else           word_next  = word_idx + WORD_W'(1);
          end else begin
            bsel_next = bsel + BSEL_W'(1);
          end
        end
      end
      CHK:     if (hs) state_next = start ? HDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next output byte, checksum, sequence and overrun count
  always_comb begin
    chk_next = checksum;
    seq_next = Frame_Seq;
    ovf_next = Overrun_Cnt;
    if (load)    chk_next = '0;
    else if (hs) chk_next = checksum ^ Tx_Data;
    if ((state == CHK) && hs) seq_next = Frame_Seq + 8'd1;
    if (start && !load && (state != IDLE) && (Overrun_Cnt != '1))
      ovf_next = Overrun_Cnt + OVF_BITS'(1);
    valid_next = (state_next != IDLE);
    busy_next  = (state_next != IDLE);
    case (state_next)
      HDR:     data_next = HEADER;
      SEQ:     data_next = Frame_Seq;
      DATA:    data_next = mux_byte;
      CHK:     data_next = chk_next;
      default: data_next = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_count_frame_serializer.sv
// Directed scoreboard bench for count_frame_serializer (NBITS=4 and NBITS=12).
module tb_count_frame_serializer;

  logic         clk = 1'b0;
  logic         rst_n, enable, wd, ready;
  logic [43:0]  counts;
  logic [7:0]   txd, fseq, ovf;
  logic         txv, busy;

  logic         wd12, ready12;
  logic [131:0] counts12;
  logic [7:0]   txd12, fseq12, ovf12;
  logic         txv12, busy12;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   q[$];
  logic [7:0]   q12[$];
  logic         prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]   prev_d = 8'h00;
  int           cyc;

  always #5 clk = ~clk;

  count_frame_serializer #(.NBITS(4), .HEADER(8'hA5), .OVF_BITS(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .Enable(enable), .Window_Done(wd), .Counts_In(counts),
    .Tx_Data(txd), .Tx_Valid(txv), .Tx_Ready(ready), .Busy(busy),
    .Frame_Seq(fseq), .Overrun_Cnt(ovf)
  );

  count_frame_serializer #(.NBITS(12), .HEADER(8'hA5), .OVF_BITS(8)) dut12 (
    .Clk(clk), .Rst_n(rst_n), .Enable(1'b1), .Window_Done(wd12), .Counts_In(counts12),
    .Tx_Data(txd12), .Tx_Valid(txv12), .Tx_Ready(ready12), .Busy(busy12),
    .Frame_Seq(fseq12), .Overrun_Cnt(ovf12)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte scoreboard and stall-stability monitor for the NBITS=4 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r)
        check("stall_hold", {23'b0, txv, txd}, {23'b0, 1'b1, prev_d});
      if (txv && ready) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL extra_byte observed=%0h expected=none", txd);
        end
        if (q.size() != 0) check("frame_byte", 32'(txd), 32'(q.pop_front()));
      end
    end
    prev_v = txv;
    prev_r = ready;
    prev_d = txd;
  end

  // Byte scoreboard for the NBITS=12 instance
  always @(negedge clk) begin
    if (rst_n && txv12 && ready12) begin
      checks++;
      assert (q12.size() != 0) else begin
        errors++;
        $error("FAIL extra_byte12 observed=%0h expected=none", txd12);
      end
      if (q12.size() != 0) check("frame_byte12", 32'(txd12), 32'(q12.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    wd = 1'b1;
    tick();
    wd = 1'b0;
  endtask

  task automatic push_frame4(input logic [7:0] seq, input logic [43:0] c);
    logic [7:0] x, b;
    x = 8'hA5 ^ seq;
    q.push_back(8'hA5);
    q.push_back(seq);
    for (int w = 0; w < 11; w++) begin
      b = 8'(c[w*4 +: 4]);
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(x);
  endtask

  task automatic push_frame12(input logic [7:0] seq, input logic [131:0] c);
    logic [7:0]  x;
    logic [15:0] v;
    x = 8'hA5 ^ seq;
    q12.push_back(8'hA5);
    q12.push_back(seq);
    for (int w = 0; w < 11; w++) begin
      v = 16'(c[w*12 +: 12]);
      q12.push_back(v[15:8]);
      q12.push_back(v[7:0]);
      x = x ^ v[15:8] ^ v[7:0];
    end
    q12.push_back(x);
  endtask

  task automatic drain(input int budget, input bit rnd, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < budget) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    ready = 1'b1;
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; wd = 1'b0; ready = 1'b1; counts = '0;
    wd12 = 1'b0; ready12 = 1'b1; counts12 = '0;
    tick(); tick();
    check("rst_valid", 32'(txv), 32'd0);
    check("rst_data",  32'(txd), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_seq",   32'(fseq), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame with continuous ready
    counts = 44'hA987654321F;
    push_frame4(8'h00, counts);
    pulse();
    check("first_valid", 32'(txv), 32'd1);
    check("first_byte",  32'(txd), 32'hA5);
    drain(100, 1'b0, cyc);
    check("no_bubble_len", 32'(cyc), 32'd14);
    check("done_busy",  32'(busy), 32'd0);
    check("done_valid", 32'(txv), 32'd0);
    check("done_seq",   32'(fseq), 32'd1);

    // Random backpressure
    push_frame4(8'h01, counts);
    pulse();
    drain(400, 1'b1, cyc);
    check("rand_seq", 32'(fseq), 32'd2);

    // Overruns while stalled; snapshot isolation
    ready = 1'b0;
    push_frame4(8'h02, counts);
    pulse();
    counts = '0;
    tick();
    pulse();
    tick();
    pulse();
    pulse();
    check("ovf_three", 32'(ovf), 32'd3);
    check("ovf_busy",  32'(busy), 32'd1);
    ready = 1'b1;
    drain(100, 1'b0, cyc);
    check("ovf_seq", 32'(fseq), 32'd3);

    // Window coincident with the checksum handshake
    counts = 44'hA987654321F;
    push_frame4(8'h03, counts);
    pulse();
    repeat (13) tick();
    push_frame4(8'h04, counts);
    pulse();
    check("b2b_valid", 32'(txv), 32'd1);
    check("b2b_header", 32'(txd), 32'hA5);
    check("b2b_ovf", 32'(ovf), 32'd3);
    drain(100, 1'b0, cyc);
    check("b2b_seq", 32'(fseq), 32'd5);

    // Disabled window is ignored
    enable = 1'b0;
    pulse();
    tick();
    check("dis_valid", 32'(txv), 32'd0);
    check("dis_busy",  32'(busy), 32'd0);
    check("dis_ovf",   32'(ovf), 32'd3);
    enable = 1'b1;

    // Reset in the middle of the data bytes
    push_frame4(8'h05, counts);
    pulse();
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    check("mrst_valid", 32'(txv), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_seq",   32'(fseq), 32'd0);
    check("mrst_ovf",   32'(ovf), 32'd0);
    push_frame4(8'h00, counts);
    pulse();
    drain(100, 1'b0, cyc);
    check("mrst_next_seq", 32'(fseq), 32'd1);

    // Wide words: two bytes per word
    counts12 = 132'(12'hABC) << 60;
    push_frame12(8'h00, counts12);
    wd12 = 1'b1;
    tick();
    wd12 = 1'b0;
    cyc = 0;
    while (q12.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("w12_drain", 32'(q12.size()), 32'd0);
    check("w12_len",   32'(cyc), 32'd25);
    check("w12_busy",  32'(busy12), 32'd0);
    check("w12_seq",   32'(fseq12), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_frame_serializer.md
Name: count_frame_serializer

Overview:
Downstream consumer of the coincidence detector top. When an integration window completes, it snapshots the detector's 11 count words (Cnt_Clk, Counts_A..D, Counts_AB..CD) in one cycle. It then streams them out as a checksummed byte frame over a valid/ready interface toward the host link (UART/FIFO bridge). Windows that end while a frame is still in flight are counted as overruns.

Parameters:
NBITS, 4, width of each count word (matches detector NBITS)
HEADER, 8'hA5, frame start byte
OVF_BITS, 8, width of saturating overrun counter

Ports:
Clk  in  1  system clock
Rst_n  in  1  synchronous active-low reset
Enable  in  1  when 0, Window_Done is ignored; a frame already in flight still completes
Window_Done  in  1  one-cycle pulse from detector at end of integration window
Counts_In  in  11*NBITS  flattened counts; word0 (LSBs)=Cnt_Clk, words 1-4=A,B,C,D, words 5-10=AB,AC,AD,BC,BD,CD
Tx_Data  out  8  frame byte
Tx_Valid  out  1  Tx_Data valid
Tx_Ready  in  1  sink accepts byte when Tx_Valid&Tx_Ready
Busy  out  1  frame in flight (state != IDLE)
Frame_Seq  out  8  sequence number of the next frame to be sent
Overrun_Cnt  out  OVF_BITS  dropped windows, saturating

Behaviour:
- Clock is Clk. Reset is synchronous and active-low on Rst_n. While Rst_n=0 at a rising edge: state=IDLE, Tx_Valid=0, Tx_Data=0, Busy=0, Frame_Seq=0, Overrun_Cnt=0, checksum=0, snapshot registers=0.
- NBYTES = ceil(NBITS/8) is a localparam. Each word is zero-extended to 8*NBYTES bits and sent MSB byte first.
- Frame length: 1 + 1 + 11*NBYTES + 1 bytes (14 at default).
- Frame byte order: HEADER, Frame_Seq, word0..word10, CHK.
- CHK = XOR of all preceding bytes of the frame, header included.
- FSM states: IDLE, HDR, SEQ, DATA, CHK.
  - IDLE: Window_Done&Enable=1 -> snapshot Counts_In on the same edge, go to HDR. Tx_Valid=1 with HEADER on the next cycle (1-cycle latency).
  - HDR -> SEQ -> DATA on each handshake.
  - DATA: a byte index runs 0..11*NBYTES-1; after the last byte, go to CHK.
  - CHK: on handshake, Frame_Seq increments (mod 256) and the state returns to IDLE.
- Handshake rules:
  - A byte transfers only when Tx_Valid&Tx_Ready.
  - Tx_Data and Tx_Valid must hold stable while Tx_Valid&!Tx_Ready.
  - Tx_Valid stays high continuously from HDR through CHK. No bubbles are allowed when Tx_Ready is held at 1, so one byte transfers per cycle.
- The checksum register accumulates on each handshake and clears when a new snapshot is taken.
- Overrun: Window_Done&Enable while in HDR, SEQ or DATA, or in CHK without a handshake -> the window is dropped. Snapshot is unchanged and Overrun_Cnt increments, saturating at all-ones.
- Simultaneous events: Window_Done&Enable in the same cycle as the CHK handshake is accepted, not dropped. The new snapshot is taken and the next state is HDR, giving back-to-back frames with no idle cycle. The new frame uses the incremented Frame_Seq.
- Snapshot isolation: Counts_In changes after the snapshot never affect the frame in flight.
- Enable=0 has no effect on a frame in flight. Window_Done pulses that arrive while Enable=0 are neither sent nor counted as overruns.
- Reset mid-frame: the next edge returns to IDLE with Tx_Valid=0. The partial frame is abandoned and the sink resynchronises on HEADER.

Decomposition:
- Shared package holds:
  - frame state enum (IDLE, HDR, SEQ, DATA, CHK)
  - HEADER default constant
  - NWORDS=11 constant
  - word-index constants matching the detector output order (WORD_CLK=0 ... WORD_CD=10)
- One sub-module, count_snapshot_mux: holds the snapshot registers and selects the byte for a given (word, byte) index.
- FSM, checksum and counters live in the top.

Test Plan:
- Default NBITS=4, Tx_Ready=1, Counts_In words 0..10 = F,1,2,3,4,5,6,7,8,9,A, one Window_Done pulse -> 14 consecutive bytes A5 00 0F 01 02 03 04 05 06 07 08 09 0A A1; Busy low after the last byte; Frame_Seq=1.
- Same stimulus with Tx_Ready toggling 1/0 randomly -> identical byte sequence; Tx_Data stable during every stall; no duplicated or skipped bytes.
- Three Window_Done pulses during a stalled frame (Tx_Ready=0) -> Overrun_Cnt=3. The frame, once released, carries the original snapshot even though Counts_In was changed to all-zero after capture.
- Window_Done coincident with the CHK handshake -> next cycle Tx_Data=A5 with Tx_Valid=1, second frame's sequence byte = 01, Overrun_Cnt unchanged. Window_Done with Enable=0 in IDLE -> no frame and no overrun.
- Rst_n=0 for one cycle while in DATA -> next cycle Tx_Valid=0, Busy=0, Frame_Seq=0, Overrun_Cnt=0. A following Window_Done produces a complete fresh frame with sequence byte 00.
- NBITS=12, Counts_AB=12'hABC, other words 0 -> frame of 25 bytes. The word 5 bytes are 0A then BC. CHK = A5^00^0A^BC = 13.
